multicycle_adder: RTL and testbench
===================================

// Module: multicycle_adder
// PURPOSE
//   Parametrised sequential successor to the single-bit full adder.
//   Adds two WIDTH-bit operands plus carry-in over WIDTH/CHUNK clock cycles.
//   Each cycle a CHUNK-bit ripple slice is processed and the carry is registered between slices.
//   Used where a full-width single-cycle carry chain would miss timing; valid/ready on both sides.
// PARAMETERS
//   WIDTH  32  operand/result width in bits; must be an integer multiple of CHUNK
//   CHUNK   8  bits added per cycle; CHUNK==WIDTH gives a 1-cycle RUN phase
// PORTS
//   clk        in   1      rising-edge clock; single clock domain
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands a/b/cin valid
//   in_ready   out  1      block can accept operands
//   a          in   WIDTH  operand A, unsigned (two's-complement for ovf)
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in into bit 0
//   out_valid  out  1      sum/cout valid
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  a + b + cin, modulo 2^WIDTH
//   cout       out  1      carry out of bit WIDTH-1
//   ovf        out  1      signed overflow; present only with OVERFLOW_FLAG_EN
// BEHAVIOUR
//   Reset: is asynchronous and active-low.
//   - Asserting rst_n low forces: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
//   - Chunk counter and carry register are cleared.
//   FSM states: IDLE, RUN, DONE.
//   IDLE: in_ready=1.
//   - On in_valid&&in_ready, latch a, b, cin into internal registers.
//   - Clear chunk index; next state is RUN.
//   RUN: in_ready=0.
//   - Each cycle, compute {c, s} = a_chunk[i] + b_chunk[i] + carry.
//   - Write s into sum bits [i*CHUNK +: CHUNK]; carry <= c; i <= i+1.
//   - After chunk NCHUNK-1 (NCHUNK = WIDTH/CHUNK): cout <= final carry; next state is DONE.
//   DONE: out_valid=1.
//   - sum, cout and ovf hold stable until out_ready is high.
//   - On out_valid&&out_ready, next state is IDLE and out_valid drops next cycle.
//   Latency: out_valid rises exactly NCHUNK cycles after the accepting edge.
//   Throughput: one operation per NCHUNK+2 cycles.
//   No accept in the same cycle as a result handoff: in_ready is 0 in DONE.
//   Backpressure: DONE persists indefinitely with outputs frozen.
//   - Input changes on a/b/cin while not in IDLE are ignored (operands are latched).
//   Partial results: sum bits are visible but undefined while in RUN.
//   - Consumers sample only when out_valid=1.
//   After a handoff, sum/cout/ovf retain the last result until the next RUN overwrites them.
//   Reset mid-RUN or mid-DONE: the operation is aborted and no result is emitted.
//   Counter width: $clog2(NCHUNK), minimum 1 bit; no wrap beyond NCHUNK-1.
//   CHUNK==WIDTH: RUN lasts one cycle; latency is 1.
// CONFIGURATION
//   OVERFLOW_FLAG_EN defined:
//   - ovf port exists; set in the last RUN cycle.
//   - ovf = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]), where sum includes cin.
//   - Registered with cout and held through DONE.
//   OVERFLOW_FLAG_EN undefined: no ovf port and no associated logic; all else identical.
// TESTING (WIDTH=32, CHUNK=8 unless stated)
//   1. Reset: hold rst_n=0, then release -> in_ready=1, out_valid=0, sum=0, cout=0.
//   2. a=FFFFFFFF, b=00000001, cin=0 -> out_valid 4 cycles after accept; sum=00000000, cout=1.
//   3. a=12345678, b=87654321, cin=1 -> sum=9999999A, cout=0; in_ready=0 during RUN/DONE.
//   4. Backpressure: out_ready=0 for 5 cycles in DONE.
//      -> out_valid stays 1; sum and cout stable; in_ready=0.
//      -> Raising out_ready returns the block to IDLE next cycle.
//   5. rst_n pulsed low at RUN chunk 2 -> outputs at reset values; no out_valid follows.
//      -> Next operation 00000003+00000004 gives sum=00000007.
//   6. OVERFLOW_FLAG_EN: 7FFFFFFF+00000001 -> ovf=1, cout=0.
//      -> 80000000+80000000 gives sum=0, cout=1, ovf=1.
//      -> WIDTH=CHUNK=4: all 512 a/b/cin combinations match the reference model with latency 1.

Source files
------------

// File: rtl/multicycle_adder_if.sv
// Operand/result handshake bundle for multicycle_adder.
// master = producer/consumer side, slave = adder side.
// Optional ovf flag exists only when OVERFLOW_FLAG_EN is defined.
interface multicycle_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef OVERFLOW_FLAG_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef OVERFLOW_FLAG_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef OVERFLOW_FLAG_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/multicycle_adder.sv
// Sequential adder: WIDTH-bit a+b+cin computed CHUNK bits per cycle, carry registered between slices.
// Latency: out_valid rises WIDTH/CHUNK cycles after the accepting edge; one op per WIDTH/CHUNK+2 cycles.
// Backpressure: result held frozen in DONE until out_ready; in_ready low outside IDLE. Macro: OVERFLOW_FLAG_EN adds ovf.
module multicycle_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_adder_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [CW-1:0]    idx;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
`ifdef OVERFLOW_FLAG_EN
    logic             ovf_q;
`endif

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_res;
    logic             last_chunk;

    // One CHUNK-bit ripple slice selected by the chunk index, plus the carry from the previous slice
    always_comb begin
        a_chunk    = a_q[int'(idx) * CHUNK +: CHUNK];
        b_chunk    = b_q[int'(idx) * CHUNK +: CHUNK];
        chunk_res  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
        last_chunk = (idx == LAST_IDX);
    end

    // Control FSM with registered handshake outputs and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            carry       <= 1'b0;
            idx         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        carry      <= bus.cin;
                        idx        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    sum_q[int'(idx) * CHUNK +: CHUNK] <= chunk_res[CHUNK-1:0];
                    carry <= chunk_res[CHUNK];
                    if (last_chunk) begin
                        // Final slice: publish carry-out (and overflow) together with out_valid
                        cout_q      <= chunk_res[CHUNK];
`ifdef OVERFLOW_FLAG_EN
                        ovf_q       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                       (chunk_res[CHUNK-1] != a_q[WIDTH-1]);
`endif
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + CW'(1);
                    end
                end
                DONE: begin
                    // No accept in the handoff cycle; in_ready returns with IDLE
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
`ifdef OVERFLOW_FLAG_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_multicycle_adder.sv
// Self-checking bench for multicycle_adder: 32/8 instance with directed and random ops,
// plus a 4/4 instance swept over every a/b/cin combination.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_multicycle_adder;
    logic clk;
    logic rst_n;

    int total;
    int passed;

    multicycle_adder_if #(.WIDTH(32)) bus32 ();
    multicycle_adder_if #(.WIDTH(4))  bus4 ();

    multicycle_adder #(.WIDTH(32), .CHUNK(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus32)
    );

    multicycle_adder #(.WIDTH(4), .CHUNK(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: unsigned sum of width w, including carry-out in bit w
    function automatic longint ref_full(input longint ua, input longint ub, input longint c);
        return ua + ub + c;
    endfunction

    // Reference: signed overflow when the true signed sum leaves the w-bit range
    function automatic logic ref_ovf(input longint ua, input longint ub, input longint c, input int w);
        longint half;
        longint sa;
        longint sb;
        longint r;
        half = longint'(1) << (w - 1);
        sa   = (ua >= half) ? ua - 2 * half : ua;
        sb   = (ub >= half) ? ub - 2 * half : ub;
        r    = sa + sb + c;
        return (r >= half) || (r < -half);
    endfunction

    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                          input int bp, input string tag);
        longint      full;
        logic [31:0] es;
        logic        ec;
        int          cnt;
        full = ref_full(longint'(av), longint'(bv), longint'(cv));
        es   = full[31:0];
        ec   = full[32];
        @(negedge clk);
        check({tag, ":in_ready_idle"}, 64'(bus32.in_ready), 64'd1);
        bus32.a         = av;
        bus32.b         = bv;
        bus32.cin       = cv;
        bus32.in_valid  = 1'b1;
        bus32.out_ready = 1'b0;
        @(negedge clk);
        // Operands are latched; scrambling the inputs must not disturb the result
        bus32.in_valid = 1'b0;
        bus32.a        = $urandom;
        bus32.b        = $urandom;
        bus32.cin      = 1'($urandom_range(1, 0));
        check({tag, ":in_ready_run"}, 64'(bus32.in_ready), 64'd0);
        cnt = 0;
        while (bus32.out_valid !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, ":latency"}, 64'(cnt), 64'd4);
        check({tag, ":out_valid"}, 64'(bus32.out_valid), 64'd1);
        check({tag, ":sum"}, 64'(bus32.sum), 64'(es));
        check({tag, ":cout"}, 64'(bus32.cout), 64'(ec));
        check({tag, ":in_ready_done"}, 64'(bus32.in_ready), 64'd0);
`ifdef OVERFLOW_FLAG_EN
        check({tag, ":ovf"}, 64'(bus32.ovf), 64'(ref_ovf(longint'(av), longint'(bv), longint'(cv), 32)));
`endif
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check({tag, ":bp_valid"}, 64'(bus32.out_valid), 64'd1);
            check({tag, ":bp_sum"}, 64'(bus32.sum), 64'(es));
            check({tag, ":bp_cout"}, 64'(bus32.cout), 64'(ec));
            check({tag, ":bp_in_ready"}, 64'(bus32.in_ready), 64'd0);
        end
        bus32.out_ready = 1'b1;
        @(negedge clk);
        bus32.out_ready = 1'b0;
        check({tag, ":post_valid"}, 64'(bus32.out_valid), 64'd0);
        check({tag, ":post_in_ready"}, 64'(bus32.in_ready), 64'd1);
        check({tag, ":post_sum_hold"}, 64'(bus32.sum), 64'(es));
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        longint      full4;
        total = 0;
        passed = 0;
        bus32.in_valid  = 1'b0;
        bus32.a         = '0;
        bus32.b         = '0;
        bus32.cin       = 1'b0;
        bus32.out_ready = 1'b0;
        bus4.in_valid   = 1'b0;
        bus4.a          = '0;
        bus4.b          = '0;
        bus4.cin        = 1'b0;
        bus4.out_ready  = 1'b1;

        // Step 1: reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst:in_ready", 64'(bus32.in_ready), 64'd1);
        check("rst:out_valid", 64'(bus32.out_valid), 64'd0);
        check("rst:sum", 64'(bus32.sum), 64'd0);
        check("rst:cout", 64'(bus32.cout), 64'd0);
        check("rst4:in_ready", 64'(bus4.in_ready), 64'd1);
        check("rst4:out_valid", 64'(bus4.out_valid), 64'd0);

        // Steps 2-4: directed operations, the second with 5 cycles of backpressure
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, "wrap");
        run_op(32'h1234_5678, 32'h8765_4321, 1'b1, 5, "mix_bp");

        // Step 5: reset during RUN at chunk 2 aborts the operation
        @(negedge clk);
        bus32.a        = 32'hDEAD_BEEF;
        bus32.b        = 32'h1111_1111;
        bus32.cin      = 1'b1;
        bus32.in_valid = 1'b1;
        @(negedge clk);
        bus32.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort:in_ready", 64'(bus32.in_ready), 64'd1);
        check("abort:out_valid", 64'(bus32.out_valid), 64'd0);
        check("abort:sum", 64'(bus32.sum), 64'd0);
        check("abort:cout", 64'(bus32.cout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus32.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort:no_valid", 64'(bus32.out_valid), 64'd0);
        end
        bus32.out_ready = 1'b0;
        run_op(32'h0000_0003, 32'h0000_0004, 1'b0, 0, "after_abort");

        // Step 6: signed overflow corners
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, "ovf_pos");
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1, "ovf_neg");
        run_op(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 0, "ovf_cin");

        // Random operations with random backpressure
        for (int n = 0; n < 20; n++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(1, 0));
            run_op(ra, rb, rc, int'($urandom_range(3, 0)), "rand");
        end

        // Exhaustive sweep of the single-chunk configuration
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    full4 = ref_full(longint'(ia), longint'(ib), longint'(ic));
                    @(negedge clk);
                    check("w4:in_ready", 64'(bus4.in_ready), 64'd1);
                    bus4.a        = 4'(ia);
                    bus4.b        = 4'(ib);
                    bus4.cin      = 1'(ic);
                    bus4.in_valid = 1'b1;
                    @(negedge clk);
                    bus4.in_valid = 1'b0;
                    @(negedge clk);
                    check("w4:out_valid", 64'(bus4.out_valid), 64'd1);
                    check("w4:sum", 64'(bus4.sum), 64'(full4[3:0]));
                    check("w4:cout", 64'(bus4.cout), 64'(full4[4]));
`ifdef OVERFLOW_FLAG_EN
                    check("w4:ovf", 64'(bus4.ovf),
                          64'(ref_ovf(longint'(ia), longint'(ib), longint'(ic), 4)));
`endif
                end
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
